// File: rtl/decoder.sv
// Row/column parity decoder: scans one data byte per cycle, then corrects a
// single-bit data error or classifies the syndrome pair, holding the result until accepted.
//
// state  | meaning
// IDLE   | waiting for a codeword; in_ready high
// SCAN   | accumulating row and column syndromes, one byte per cycle
// DECIDE | classifying syndromes and computing the corrected data
// OUT    | loading the result, then holding it until out_ready
module decoder (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] codeword,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  data_out,
    output logic [1:0]   status,
    output logic [2:0]   error_row,
    output logic [2:0]   error_col,
    output logic [15:0]  corr_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DECIDE = 2'd2,
        OUT    = 2'd3
    } state_t;

    localparam logic [1:0] ST_CLEAN     = 2'b00;
    localparam logic [1:0] ST_CORRECTED = 2'b01;
    localparam logic [1:0] ST_UNCORR    = 2'b10;
    localparam logic [1:0] ST_CHECK_ERR = 2'b11;

    state_t      state, next_state;

    logic [63:0] cw_data;
    logic [7:0]  row_par;
    logic [7:0]  col_par;
    logic [7:0]  row_syn;
    logic [7:0]  col_acc;
    logic [7:0]  col_syn;
    logic [2:0]  row_cnt;
    logic [7:0]  cur_byte;

    logic [63:0] dec_data;
    logic [1:0]  dec_status;
    logic [2:0]  dec_row;
    logic [2:0]  dec_col;

    logic [63:0] nxt_data;
    logic [1:0]  nxt_status;
    logic [2:0]  nxt_row;
    logic [2:0]  nxt_col;
    logic        row_one;
    logic        col_one;
    logic        unused_resv;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [2:0] bit_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    // Reserved middle bits of the codeword carry no information.
    assign unused_resv = ^codeword[63:16];

    assign cur_byte = cw_data[{row_cnt, 3'b000} +: 8];
    assign in_ready = (state == IDLE) && !rst;
    assign row_one  = is_onehot(row_syn);
    assign col_one  = is_onehot(col_syn);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = SCAN;
            SCAN:    if (row_cnt == 3'd7) next_state = DECIDE;
            DECIDE:  next_state = OUT;
            OUT:     if (out_valid && out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        nxt_data   = cw_data;
        nxt_status = ST_UNCORR;
        nxt_row    = 3'd0;
        nxt_col    = 3'd0;
        if (row_syn == 8'd0 && col_syn == 8'd0) begin
            nxt_status = ST_CLEAN;
        end else if (row_one && col_one) begin
            nxt_status = ST_CORRECTED;
            nxt_row    = bit_index(row_syn);
            nxt_col    = bit_index(col_syn);
            nxt_data   = cw_data ^ (64'd1 << {nxt_row, nxt_col});
        end else if ((row_one && col_syn == 8'd0) || (col_one && row_syn == 8'd0)) begin
            // A lone syndrome bit points at a flipped parity bit, not at data.
            nxt_status = ST_CHECK_ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cw_data    <= 64'd0;
            row_par    <= 8'd0;
            col_par    <= 8'd0;
            row_syn    <= 8'd0;
            col_acc    <= 8'd0;
            col_syn    <= 8'd0;
            row_cnt    <= 3'd0;
            dec_data   <= 64'd0;
            dec_status <= ST_CLEAN;
            dec_row    <= 3'd0;
            dec_col    <= 3'd0;
            out_valid  <= 1'b0;
            data_out   <= 64'd0;
            status     <= ST_CLEAN;
            error_row  <= 3'd0;
            error_col  <= 3'd0;
            corr_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cw_data <= codeword[127:64];
                        row_par <= codeword[7:0];
                        col_par <= codeword[15:8];
                        row_syn <= 8'd0;
                        col_acc <= 8'd0;
                        col_syn <= 8'd0;
                        row_cnt <= 3'd0;
                    end
                end
                SCAN: begin
                    row_syn[row_cnt] <= (^cur_byte) ^ row_par[row_cnt];
                    col_acc          <= col_acc ^ cur_byte;
                    row_cnt          <= row_cnt + 3'd1;
                    if (row_cnt == 3'd7) begin
                        col_syn <= col_acc ^ cur_byte ^ col_par;
                    end
                end
                DECIDE: begin
                    dec_data   <= nxt_data;
                    dec_status <= nxt_status;
                    dec_row    <= nxt_row;
                    dec_col    <= nxt_col;
                end
                OUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        data_out  <= dec_data;
                        status    <= dec_status;
                        error_row <= dec_row;
                        error_col <= dec_col;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (status == ST_CORRECTED && corr_count != 16'hFFFF) begin
                            corr_count <= corr_count + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder.sv
// Bench for the row/column parity decoder: directed spec cases plus random
// codewords checked against a plain-arithmetic syndrome model.
module tb_decoder;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] codeword;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  data_out;
    logic [1:0]   status;
    logic [2:0]   error_row;
    logic [2:0]   error_col;
    logic [15:0]  corr_count;

    int           vectors = 0;
    int           miscompares = 0;
    logic [15:0]  exp_corr = 16'd0;

    decoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .codeword   (codeword),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .status     (status),
        .error_row  (error_row),
        .error_col  (error_col),
        .corr_count (corr_count)
    );

    always #5 clk = ~clk;

    // Expected {status, error_row, error_col, data_out} from the parity rules.
    function automatic logic [71:0] model(input logic [127:0] cw);
        int          nr, nc, ri, ci;
        logic [63:0] d;
        logic [1:0]  st;
        logic [2:0]  er, ec;
        nr = 0; nc = 0; ri = 0; ci = 0;
        d  = cw[127:64];
        for (int r = 0; r < 8; r++) begin
            int p;
            p = int'(cw[r]);
            for (int c = 0; c < 8; c++) p = p + int'(d[r*8+c]);
            if (p % 2 == 1) begin nr++; ri = r; end
        end
        for (int c = 0; c < 8; c++) begin
            int p;
            p = int'(cw[8+c]);
            for (int r = 0; r < 8; r++) p = p + int'(d[r*8+c]);
            if (p % 2 == 1) begin nc++; ci = c; end
        end
        er = 3'd0; ec = 3'd0;
        if (nr == 0 && nc == 0) st = 2'b00;
        else if (nr == 1 && nc == 1) begin
            st = 2'b01;
            er = 3'(ri);
            ec = 3'(ci);
            d[ri*8+ci] = ~d[ri*8+ci];
        end else if ((nr == 1 && nc == 0) || (nr == 0 && nc == 1)) st = 2'b11;
        else st = 2'b10;
        return {st, er, ec, d};
    endfunction

    function automatic logic [15:0] parity_of(input logic [63:0] d);
        logic [7:0] rp, cp;
        rp = 8'd0; cp = 8'd0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                rp[r] = rp[r] ^ d[r*8+c];
                cp[c] = cp[c] ^ d[r*8+c];
            end
        return {cp, rp};
    endfunction

    task automatic run_one(input logic [127:0] cw, input int stall, input logic poke);
        logic [71:0] exp;
        int          cnt;
        exp = model(cw);
        @(negedge clk);
        in_valid = 1'b1;
        codeword = cw;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_idle: got %b want 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        codeword = {$urandom, $urandom, $urandom, $urandom};
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end while (out_valid !== 1'b1 && cnt < 20);
        vectors++;
        if (cnt != 10 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles (out_valid=%b) want 10", cnt, out_valid);
        end
        vectors++;
        if ({status, error_row, error_col, data_out} !== exp) begin
            miscompares++;
            $display("FAIL result cw=%h: got st=%b row=%0d col=%0d data=%h want st=%b row=%0d col=%0d data=%h",
                     cw, status, error_row, error_col, data_out, exp[71:70], exp[69:67], exp[66:64], exp[63:0]);
        end
        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                in_valid = 1'b1;
                codeword = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {status, error_row, error_col, data_out} !== exp) begin
                miscompares++;
                $display("FAIL hold cycle %0d: got v=%b rdy=%b st=%b data=%h want v=1 rdy=0 st=%b data=%h",
                         s, out_valid, in_ready, status, data_out, exp[71:70], exp[63:0]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (exp[71:70] == 2'b01 && exp_corr != 16'hFFFF) exp_corr = exp_corr + 16'd1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || corr_count !== exp_corr) begin
            miscompares++;
            $display("FAIL accept: got v=%b rdy=%b corr=%0d want v=0 rdy=1 corr=%0d",
                     out_valid, in_ready, corr_count, exp_corr);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (out_valid !== 1'b0 || data_out !== 64'd0 || status !== 2'b00 || error_row !== 3'd0 ||
            error_col !== 3'd0 || corr_count !== 16'd0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got v=%b data=%h st=%b row=%0d col=%0d corr=%0d rdy=%b want all 0",
                     tag, out_valid, data_out, status, error_row, error_col, corr_count, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; codeword = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_values");
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [63:0] d;
        run_one(128'h0, 0, 1'b0);
        d = 64'h0000_0000_0020_0000;
        run_one({d, 64'h0}, 0, 1'b0);
        d = 64'h0000_0000_0000_0201;
        run_one({d, 64'h0}, 1, 1'b0);
        run_one({64'h0, 64'h8}, 0, 1'b0);
        // Reserved bits set everywhere must not change a clean result.
        d = 64'h1234_5678_9ABC_DEF0;
        run_one({d, 48'hFFFF_FFFF_FFFF, parity_of(d)}, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_one({64'h0000_0000_0020_0000, 64'h0}, 5, 1'b1);
        vectors++;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) break;
        end
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_input: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [63:0]  d;
            logic [15:0]  chk;
            logic [47:0]  resv;
            logic [127:0] cw;
            int           mode, a, b;
            d    = {$urandom, $urandom};
            resv = {$urandom, $urandom};
            chk  = parity_of(d);
            mode = int'($urandom_range(0, 4));
            a    = int'($urandom_range(0, 63));
            b    = (a + int'($urandom_range(1, 63))) % 64;
            case (mode)
                1: d[a] = ~d[a];
                2: begin d[a] = ~d[a]; d[b] = ~d[b]; end
                3: chk[a % 16] = ~chk[a % 16];
                default: ;
            endcase
            cw = {d, resv, chk};
            if (mode == 4) cw = {$urandom, $urandom, $urandom, $urandom};
            run_one(cw, int'($urandom_range(0, 3)), n[0]);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [63:0] d;
        int          seen;
        d = 64'h0000_0100_0000_0000;
        @(negedge clk);
        in_valid = 1'b1;
        codeword = {d, 64'h0};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_mid_scan");
        rst = 1'b0;
        exp_corr = 16'd0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL discard_after_reset: got %0d out_valid cycles rdy=%b want 0 rdy=1", seen, in_ready);
        end
        run_one({d, 64'h0}, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
